// File: rtl/puf_common_pkg.sv
// -----------------------------------------------------------------------------
// puf_common_pkg
// Shared definitions for the PUF authentication datapath storage primitives.
//   DFF_MAX_WIDTH : widest register dff_preset_clear may be built with.
//   ctrl_t        : single-bit control signal type (clocks, clear, preset).
// -----------------------------------------------------------------------------
package puf_common_pkg;

  localparam int DFF_MAX_WIDTH = 64;

  typedef logic ctrl_t;

endpackage : puf_common_pkg

// File: rtl/dff_preset_clear_if.sv
// -----------------------------------------------------------------------------
// dff_preset_clear_if
// Data bus of the dff_preset_clear register.
//   d : data to be captured on the next rising clk edge (master -> slave)
//   q : registered value                                (slave  -> master)
// -----------------------------------------------------------------------------
interface dff_preset_clear_if #(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (output d, input  q);
  modport slave  (input  d, output q);

endinterface : dff_preset_clear_if

// File: rtl/dff_bit.sv
// -----------------------------------------------------------------------------
// dff_bit
// One bit of storage with asynchronous active-low clear and asynchronous
// active-high preset. Clear has priority over preset.
//   clk : rising-edge clock
//   CLR : asynchronous clear, active-low, forces q to CLR_VAL
//   Pre : asynchronous preset, active-high, forces q to PRE_VAL
//   d   : data captured on rising clk edge
//   q   : stored value
// -----------------------------------------------------------------------------
module dff_bit
  import puf_common_pkg::*;
#(
  parameter logic CLR_VAL = 1'b0,
  parameter logic PRE_VAL = 1'b1
) (
  input  ctrl_t clk,
  input  ctrl_t CLR,
  input  ctrl_t Pre,
  input  logic  d,
  output logic  q
);

  logic q_q;

  always_ff @(posedge clk or negedge CLR or posedge Pre) begin
    if (!CLR) begin
      q_q <= CLR_VAL;
    end else if (Pre) begin
      q_q <= PRE_VAL;
    end else begin
      q_q <= d;
    end
  end

  // Releasing CLR while Pre is still high produces no edge on the storage
  // process, so the preset level is also applied on the output path to make
  // it visible at once. The stored bit picks the preset value up on the next
  // clk edge. Only CLR/Pre feed this mux; d reaches q solely through q_q.
  always_comb begin
    q = q_q;
    if (!CLR) begin
      q = CLR_VAL;
    end else if (Pre) begin
      q = PRE_VAL;
    end
  end

endmodule : dff_bit

// File: rtl/dff_preset_clear.sv
// -----------------------------------------------------------------------------
// dff_preset_clear
// WIDTH-bit D register with asynchronous clear (to CLR_VAL) and asynchronous
// preset (to PRE_VAL); clear wins when both are asserted. Used for response
// capture and challenge latching in the PUF authentication datapath.
//   clk     : rising-edge clock
//   CLR     : asynchronous clear, active-low
//   Pre     : asynchronous preset, active-high
//   bus.d   : data in  (WIDTH bits)
//   bus.q   : data out (WIDTH bits), one clk edge of latency
// -----------------------------------------------------------------------------
module dff_preset_clear
  import puf_common_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
  input ctrl_t               clk,
  input ctrl_t               CLR,
  input ctrl_t               Pre,
  dff_preset_clear_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > DFF_MAX_WIDTH) begin : g_bad_width
    $error("dff_preset_clear: WIDTH=%0d outside 1..%0d", WIDTH, DFF_MAX_WIDTH);
  end

  logic [WIDTH-1:0] q_w;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .CLR_VAL (CLR_VAL[i]),
      .PRE_VAL (PRE_VAL[i])
    ) u_bit (
      .clk (clk),
      .CLR (CLR),
      .Pre (Pre),
      .d   (bus.d[i]),
      .q   (q_w[i])
    );
  end

  assign bus.q = q_w;

endmodule : dff_preset_clear

// File: tb/tb_dff_preset_clear.sv
`timescale 1ns/1ps
module tb_dff_preset_clear;

  logic clk;
  logic clr1, pre1;
  logic clr8, pre8;

  int errors = 0;
  int checks = 0;

  dff_preset_clear_if #(.WIDTH(1)) bus1 ();
  dff_preset_clear_if #(.WIDTH(8)) bus8 ();

  dff_preset_clear #(.WIDTH(1)) dut1 (
    .clk (clk),
    .CLR (clr1),
    .Pre (pre1),
    .bus (bus1)
  );

  dff_preset_clear #(
    .WIDTH   (8),
    .CLR_VAL (8'h5A),
    .PRE_VAL (8'hC3)
  ) dut8 (
    .clk (clk),
    .CLR (clr8),
    .Pre (pre8),
    .bus (bus8)
  );

  // Rising edges at 200, 400, 600, ... ns
  initial clk = 1'b1;
  always #100 clk = ~clk;

  typedef struct {
    logic       clr;
    logic       pre;
    logic [7:0] d;
    logic       sync;   // 1: check after the next rising edge; 0: check at once
    logic [7:0] exp_q;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: q=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h5A};
    vecs[1]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 8'h5A};
    vecs[2]  = '{1'b1, 1'b1, 8'hA5, 1'b0, 8'hC3};
    vecs[3]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 8'hC3};
    vecs[4]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 8'hC3};
    vecs[5]  = '{1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5};
    vecs[6]  = '{1'b1, 1'b0, 8'h3C, 1'b0, 8'hA5};
    vecs[7]  = '{1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C};
    vecs[8]  = '{1'b1, 1'b1, 8'h00, 1'b0, 8'hC3};
    vecs[9]  = '{1'b1, 1'b0, 8'hFF, 1'b1, 8'hFF};
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 1'b1, 8'h5A};
    vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h5A};
    vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00};

    clr8   = 1'b0;
    pre8   = 1'b0;
    bus8.d = 8'h00;

    // Async clear, 1-bit register, no clock edge yet
    clr1   = 1'b0;
    pre1   = 1'b0;
    bus1.d = 1'b1;
    #1  check("clr_async", {7'd0, bus1.q}, 8'h00);
    #40 check("clr_hold", {7'd0, bus1.q}, 8'h00);
    #4  clr1 = 1'b1;                                    // t=45
    #1  check("clr_release_hold", {7'd0, bus1.q}, 8'h00);
    #49 bus1.d = 1'b1;                                  // t=95
    @(posedge clk); #1;                                 // 200 ns edge
    check("capture_1", {7'd0, bus1.q}, 8'h01);
    #44 bus1.d = 1'b0;                                  // t=245
    #1  check("d_between_edges", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;                                 // 400 ns edge
    check("capture_0", {7'd0, bus1.q}, 8'h00);

    // Async preset mid-cycle
    #14 pre1 = 1'b1;                                    // t=415
    #1  check("pre_async", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;                                 // 600 ns edge
    check("pre_hold_edge", {7'd0, bus1.q}, 8'h01);
    #64 pre1 = 1'b0;                                    // t=665
    #1  check("pre_release_hold", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;                                 // 800 ns edge
    check("pre_release_follow", {7'd0, bus1.q}, 8'h00);

    // Priority: clear beats preset, releasing clear exposes preset
    #49 pre1 = 1'b1;
    #1  check("prio_pre", {7'd0, bus1.q}, 8'h01);
    #9  clr1 = 1'b0;
    #1  check("prio_clr_wins", {7'd0, bus1.q}, 8'h00);
    #9  clr1 = 1'b1;
    #1  check("prio_clr_release", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;
    check("prio_pre_edge", {7'd0, bus1.q}, 8'h01);
    pre1 = 1'b0;
    #1  check("prio_pre_drop_hold", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;
    check("prio_follow_d", {7'd0, bus1.q}, 8'h00);

    // Glitch immunity: three toggles on d between edges
    @(negedge clk);
    bus1.d = 1'b1;
    @(posedge clk); #1;
    check("glitch_setup", {7'd0, bus1.q}, 8'h01);
    @(negedge clk);
    bus1.d = 1'b0;
    #20 bus1.d = 1'b1;
    #20 bus1.d = 1'b0;
    #1  check("glitch_between", {7'd0, bus1.q}, 8'h01);
    @(posedge clk); #1;
    check("glitch_edge", {7'd0, bus1.q}, 8'h00);

    // Width sweep on the 8-bit register, table driven
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      clr8   = vecs[i].clr;
      pre8   = vecs[i].pre;
      bus8.d = vecs[i].d;
      if (vecs[i].sync) begin
        @(posedge clk); #1;
      end else begin
        #1;
      end
      check($sformatf("w8_vec%0d", i), bus8.q, vecs[i].exp_q);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_dff_preset_clear
